// File: rtl/cam_entry_manager.sv
// cam_entry_manager: command sequencer and entry allocator in front of one block-RAM CAM.
// Owns the valid-entry bitmap, allocates the lowest free slot on insert, rejects
// duplicate keys and hides the CAM's init and write-busy timing from the requester.
module cam_entry_manager #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [DATA_WIDTH-1:0] cmd_key_i,
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_status_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic [ADDR_WIDTH:0]   occupancy_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] cam_write_addr_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic                  cam_write_enable_o,
  output logic                  cam_write_delete_o,
  input  logic                  cam_write_busy_i,
  output logic                  cam_rst_clr_o,
  output logic [DATA_WIDTH-1:0] cam_compare_data_o,
  input  logic                  cam_match_i,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr_i
);

  localparam int unsigned Entries = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] EntriesCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OccOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] StatOk     = 2'd0;
  localparam logic [1:0] StatExists = 2'd1;
  localparam logic [1:0] StatMiss   = 2'd2;
  localparam logic [1:0] StatFull   = 2'd3;

  typedef enum logic [1:0] {
    OpInsert = 2'd0,
    OpDelete = 2'd1,
    OpLookup = 2'd2,
    OpClear  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StInitWait,
    StIdle,
    StCmp,
    StChk,
    StIssue,
    StWait,
    StClr,
    StRsp
  } state_e;

  state_e                  state_q;
  op_e                     op_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [ADDR_WIDTH-1:0]   alloc_q;
  logic [Entries-1:0]      bitmap_q;
  logic [ADDR_WIDTH:0]     occ_q;
  logic                    rsp_valid_q;
  logic [1:0]              rsp_status_q;
  logic [ADDR_WIDTH-1:0]   rsp_addr_q;
  logic                    we_q;
  logic                    wd_q;
  logic                    clr_q;
  logic [ADDR_WIDTH-1:0]   free_idx;
  logic                    is_full;

  assign is_full            = (occ_q == EntriesCnt);
  assign full_o             = is_full;
  assign occupancy_o        = occ_q;
  assign cmd_ready_o        = (state_q == StIdle) && !cam_write_busy_i;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_status_o       = rsp_status_q;
  assign rsp_addr_o         = rsp_addr_q;
  assign cam_write_addr_o   = alloc_q;
  // key_q only changes on accept, so it is stable across the whole write sequence.
  assign cam_write_data_o   = key_q;
  assign cam_compare_data_o = key_q;
  assign cam_write_enable_o = we_q;
  assign cam_write_delete_o = wd_q;
  assign cam_rst_clr_o      = clr_q;

  // Priority search for the lowest-index free slot in the bitmap.
  always_comb begin
    free_idx = '0;
    for (int i = int'(Entries) - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  // Command FSM with registered strobes, response and bitmap bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInitWait;
      op_q         <= OpInsert;
      key_q        <= '0;
      alloc_q      <= '0;
      bitmap_q     <= '0;
      occ_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= StatOk;
      rsp_addr_q   <= '0;
      we_q         <= 1'b0;
      wd_q         <= 1'b0;
      clr_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      we_q        <= 1'b0;
      wd_q        <= 1'b0;
      clr_q       <= 1'b0;
      unique case (state_q)
        StInitWait: begin
          if (!cam_write_busy_i) state_q <= StIdle;
        end
        StIdle: begin
          if (cmd_valid_i && !cam_write_busy_i) begin
            op_q <= op_e'(cmd_op_i);
            if (op_e'(cmd_op_i) == OpClear) begin
              clr_q    <= 1'b1;
              bitmap_q <= '0;
              occ_q    <= '0;
              state_q  <= StClr;
            end else begin
              key_q   <= cmd_key_i;
              state_q <= StCmp;
            end
          end
        end
        StCmp: state_q <= StChk;
        StChk: begin
          unique case (op_q)
            OpLookup: begin
              rsp_status_q <= cam_match_i ? StatOk : StatMiss;
              rsp_addr_q   <= cam_match_i ? cam_match_addr_i : '0;
              rsp_valid_q  <= 1'b1;
              state_q      <= StRsp;
            end
            OpInsert: begin
              if (cam_match_i) begin
                rsp_status_q <= StatExists;
                rsp_addr_q   <= cam_match_addr_i;
                rsp_valid_q  <= 1'b1;
                state_q      <= StRsp;
              end else if (is_full) begin
                // Full table: answer without touching the CAM.
                rsp_status_q <= StatFull;
                rsp_addr_q   <= '0;
                rsp_valid_q  <= 1'b1;
                state_q      <= StRsp;
              end else begin
                alloc_q <= free_idx;
                we_q    <= 1'b1;
                state_q <= StIssue;
              end
            end
            OpDelete: begin
              if (cam_match_i) begin
                alloc_q <= cam_match_addr_i;
                wd_q    <= 1'b1;
                state_q <= StIssue;
              end else begin
                rsp_status_q <= StatMiss;
                rsp_addr_q   <= '0;
                rsp_valid_q  <= 1'b1;
                state_q      <= StRsp;
              end
            end
            OpClear: state_q <= StIdle;
          endcase
        end
        StIssue: state_q <= StWait;
        StWait: begin
          // CAM content is final once busy drops; only then commit the bitmap.
          if (!cam_write_busy_i) begin
            unique case (op_q)
              OpInsert: begin
                bitmap_q[alloc_q] <= 1'b1;
                occ_q             <= occ_q + OccOne;
                rsp_addr_q        <= alloc_q;
              end
              OpDelete: begin
                bitmap_q[alloc_q] <= 1'b0;
                occ_q             <= occ_q - OccOne;
                rsp_addr_q        <= alloc_q;
              end
              OpLookup, OpClear: rsp_addr_q <= '0;
            endcase
            rsp_status_q <= StatOk;
            rsp_valid_q  <= 1'b1;
            state_q      <= StRsp;
          end
        end
        StClr: state_q <= StWait;
        StRsp: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_entry_manager.sv
// tb_cam_entry_manager: drives cam_entry_manager against a behavioural CAM and a
// table-level reference model of expected responses, latencies and occupancy.
module tb_cam_entry_manager;

  localparam int DW       = 16;
  localparam int AW       = 5;
  localparam int N        = 32;
  localparam int INIT_LEN = 16;
  localparam int CLR_LEN  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_key;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rsp_addr;
  logic [AW:0]   occupancy;
  logic          full;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_enable;
  logic          cam_write_delete;
  logic          cam_write_busy;
  logic          cam_rst_clr;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cam_entry_manager #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_op_i          (cmd_op),
    .cmd_key_i         (cmd_key),
    .rsp_valid_o       (rsp_valid),
    .rsp_status_o      (rsp_status),
    .rsp_addr_o        (rsp_addr),
    .occupancy_o       (occupancy),
    .full_o            (full),
    .cam_write_addr_o  (cam_write_addr),
    .cam_write_data_o  (cam_write_data),
    .cam_write_enable_o(cam_write_enable),
    .cam_write_delete_o(cam_write_delete),
    .cam_write_busy_i  (cam_write_busy),
    .cam_rst_clr_o     (cam_rst_clr),
    .cam_compare_data_o(cam_compare_data),
    .cam_match_i       (cam_match),
    .cam_match_addr_i  (cam_match_addr)
  );

  // Behavioural CAM: registered compare, busy the cycle after a strobe, write done
  // 2 cycles after enable, delete 3, clear/init busy for a fixed length.
  logic [DW-1:0] cam_key [N];
  logic          cam_vld [N];
  int            cam_cnt;
  int            cam_kind;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cam_vld[i] <= 1'b0;
      cam_write_busy <= 1'b1;
      cam_cnt        <= INIT_LEN;
      cam_kind       <= 0;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (cam_vld[i] && cam_key[i] == cam_compare_data) begin
          cam_match      <= 1'b1;
          cam_match_addr <= AW'(i);
        end
      end
      if (cam_write_busy) begin
        if (cam_cnt <= 1) begin
          cam_write_busy <= 1'b0;
          // Write-back uses the address/data presented in this cycle.
          if (cam_kind == 1) begin
            cam_vld[cam_write_addr] <= 1'b1;
            cam_key[cam_write_addr] <= cam_write_data;
          end else if (cam_kind == 2) begin
            cam_vld[cam_write_addr] <= 1'b0;
          end
        end else begin
          cam_cnt <= cam_cnt - 1;
        end
      end else if (cam_rst_clr) begin
        for (int i = 0; i < N; i++) cam_vld[i] <= 1'b0;
        cam_write_busy <= 1'b1;
        cam_cnt        <= CLR_LEN;
        cam_kind       <= 0;
      end else if (cam_write_enable) begin
        cam_write_busy <= 1'b1;
        cam_cnt        <= 1;
        cam_kind       <= 1;
      end else if (cam_write_delete) begin
        cam_write_busy <= 1'b1;
        cam_cnt        <= 2;
        cam_kind       <= 2;
      end
    end
  end

  // Port monitor: strobe counts, overlap and write address/data stability.
  int            we_pulses = 0;
  int            clr_cycles = 0;
  int            both_hi = 0;
  int            unstable = 0;
  bit            tracking = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  always @(negedge clk) begin
    if (rst) begin
      tracking = 1'b0;
    end else begin
      if (cam_write_enable) we_pulses++;
      if (cam_rst_clr) clr_cycles++;
      if (cam_write_enable && cam_write_delete) both_hi++;
      if (cam_write_enable || cam_write_delete) begin
        held_addr = cam_write_addr;
        held_data = cam_write_data;
        tracking  = 1'b1;
      end else if (tracking) begin
        if (cam_write_addr !== held_addr || cam_write_data !== held_data) unstable++;
        if (!cam_write_busy) tracking = 1'b0;
      end
    end
  end

  // Reference model: key table, valid flags and occupancy.
  logic [DW-1:0] m_key [N];
  bit            m_vld [N];
  int            m_occ = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_occ = 0;
  endfunction

  function automatic void model_apply(input int op, input logic [DW-1:0] key,
                                      output int st, output int addr, output int lat);
    int hit = -1;
    int fr  = -1;
    for (int i = 0; i < N; i++) if (m_vld[i] && m_key[i] == key) hit = i;
    for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
    st = 0;
    addr = 0;
    lat = 3;
    case (op)
      0: begin
        if (hit >= 0) begin
          st = 1;
          addr = hit;
        end else if (m_occ == N) begin
          st = 3;
        end else begin
          m_vld[fr] = 1'b1;
          m_key[fr] = key;
          m_occ++;
          addr = fr;
          lat = 6;
        end
      end
      1: begin
        if (hit >= 0) begin
          m_vld[hit] = 1'b0;
          m_occ--;
          addr = hit;
          lat = 7;
        end else begin
          st = 2;
        end
      end
      2: begin
        if (hit >= 0) addr = hit;
        else st = 2;
      end
      default: begin
        model_reset();
        lat = CLR_LEN + 3;
      end
    endcase
  endfunction

  // Issue one command and collect its response; latency counts cycles from accept.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] key,
                      output logic [1:0] st, output logic [AW-1:0] ad,
                      output int lat, output bit got, output bit leak);
    int w = 0;
    got = 1'b0;
    leak = 1'b0;
    lat = 0;
    st = '0;
    ad = '0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_key   = DW'($urandom);
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (cmd_ready) leak = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        st  = rsp_status;
        ad  = rsp_addr;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bit rose = 1'b0;
    bit early = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: got ready=%b rsp_valid=%b, expected 0 0", cmd_ready, rsp_valid);
    end
    vectors++;
    if (occupancy !== '0 || full !== 1'b0 || rsp_status !== 2'd0 || rsp_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got occ=%0d full=%b st=%0d addr=%0d, expected 0 0 0 0",
               occupancy, full, rsp_status, rsp_addr);
    end
    vectors++;
    if ({cam_write_enable, cam_write_delete, cam_rst_clr} !== 3'b000 ||
        cam_write_addr !== '0 || cam_write_data !== '0 || cam_compare_data !== '0) begin
      miscompares++;
      $display("FAIL reset_cam: got we=%b wd=%b clr=%b waddr=%0h wdata=%0h cmp=%0h, expected 0",
               cam_write_enable, cam_write_delete, cam_rst_clr, cam_write_addr,
               cam_write_data, cam_compare_data);
    end
    rst = 1'b0;
    @(negedge clk);
    if (cmd_ready) early = 1'b1;
    for (int i = 0; i < INIT_LEN + 10; i++) begin
      @(negedge clk);
      if (rsp_valid) early = 1'b1;
      if (cmd_ready) begin
        rose = 1'b1;
        break;
      end
    end
    vectors++;
    if (!rose || early) begin
      miscompares++;
      $display("FAIL init_ready: got rose=%b spurious=%b, expected rose=1 spurious=0", rose, early);
    end
    model_reset();
  endtask

  task automatic test_directed();
    logic [1:0]    ops  [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0};
    logic [DW-1:0] keys [8] = '{16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h5555,
                                16'h1234, 16'h1234, 16'h7777};
    int            cst  [8] = '{0, 0, 1, 0, 2, 0, 2, 0};
    int            cad  [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    logic [1:0]    st;
    logic [AW-1:0] ad;
    int            lat, est, ead, elat;
    bit            got, leak;
    for (int i = 0; i < 8; i++) begin
      model_apply(int'(ops[i]), keys[i], est, ead, elat);
      send(ops[i], keys[i], st, ad, lat, got, leak);
      vectors++;
      if (!got || st !== 2'(cst[i]) || ad !== AW'(cad[i]) || lat != elat || leak) begin
        miscompares++;
        $display("FAIL dir_rsp[%0d]: got valid=%b st=%0d addr=%0d lat=%0d leak=%b, expected st=%0d addr=%0d lat=%0d",
                 i, got, st, ad, lat, leak, cst[i], cad[i], elat);
      end
      vectors++;
      if (occupancy !== (AW+1)'(m_occ)) begin
        miscompares++;
        $display("FAIL dir_occ[%0d]: got %0d expected %0d", i, occupancy, m_occ);
      end
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_one_cycle: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_fill_full();
    logic [1:0]    st;
    logic [AW-1:0] ad;
    int            lat, est, ead, elat, we0;
    bit            got, leak;
    for (int i = 0; m_occ < N && i < 64; i++) begin
      model_apply(0, DW'(16'h1000 + i), est, ead, elat);
      send(2'd0, DW'(16'h1000 + i), st, ad, lat, got, leak);
      vectors++;
      if (!got || st !== 2'(est) || ad !== AW'(ead) || lat != elat) begin
        miscompares++;
        $display("FAIL fill_rsp[%0d]: got valid=%b st=%0d addr=%0d lat=%0d, expected st=%0d addr=%0d lat=%0d",
                 i, got, st, ad, lat, est, ead, elat);
      end
    end
    vectors++;
    if (full !== 1'b1 || occupancy !== 6'd32) begin
      miscompares++;
      $display("FAIL fill_full: got full=%b occ=%0d, expected 1 32", full, occupancy);
    end
    we0 = we_pulses;
    send(2'd0, 16'hF00D, st, ad, lat, got, leak);
    vectors++;
    if (!got || st !== 2'd3 || ad !== '0 || lat != 3 || we_pulses != we0) begin
      miscompares++;
      $display("FAIL ins_full: got valid=%b st=%0d addr=%0d lat=%0d we_pulses=%0d, expected st=3 addr=0 lat=3 we_pulses=%0d",
               got, st, ad, lat, we_pulses, we0);
    end
    send(2'd1, 16'hDEAD, st, ad, lat, got, leak);
    vectors++;
    if (!got || st !== 2'd2 || ad !== '0 || lat != 3 || occupancy !== 6'd32) begin
      miscompares++;
      $display("FAIL del_miss: got valid=%b st=%0d addr=%0d lat=%0d occ=%0d, expected st=2 addr=0 lat=3 occ=32",
               got, st, ad, lat, occupancy);
    end
  endtask

  task automatic test_clear();
    logic [1:0]    st;
    logic [AW-1:0] ad;
    int            lat, est, ead, elat, c0;
    bit            got, leak;
    c0 = clr_cycles;
    model_apply(3, '0, est, ead, elat);
    send(2'd3, 16'h0BAD, st, ad, lat, got, leak);
    vectors++;
    if (!got || st !== 2'd0 || ad !== '0 || lat != CLR_LEN + 3 || leak) begin
      miscompares++;
      $display("FAIL clear_rsp: got valid=%b st=%0d addr=%0d lat=%0d leak=%b, expected st=0 addr=0 lat=%0d",
               got, st, ad, lat, leak, CLR_LEN + 3);
    end
    vectors++;
    if (clr_cycles - c0 != 1 || occupancy !== '0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_state: got clr_cycles=%0d occ=%0d full=%b, expected 1 0 0",
               clr_cycles - c0, occupancy, full);
    end
    send(2'd2, 16'h1005, st, ad, lat, got, leak);
    vectors++;
    if (!got || st !== 2'd2 || ad !== '0) begin
      miscompares++;
      $display("FAIL clear_lookup: got valid=%b st=%0d addr=%0d, expected st=2 addr=0", got, st, ad);
    end
  endtask

  task automatic test_reset_mid();
    int            seen = 0;
    int            w = 0;
    logic [1:0]    st;
    logic [AW-1:0] ad;
    int            lat;
    bit            got, leak;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_key   = 16'hCAFE;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < INIT_LEN + 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    vectors++;
    if (seen != 0 || occupancy !== '0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid: got responses=%0d occ=%0d ready=%b, expected 0 0 1",
               seen, occupancy, cmd_ready);
    end
    send(2'd2, 16'hCAFE, st, ad, lat, got, leak);
    vectors++;
    if (!got || st !== 2'd2) begin
      miscompares++;
      $display("FAIL rst_mid_lookup: got valid=%b st=%0d, expected st=2", got, st);
    end
  endtask

  task automatic test_random();
    logic [1:0]    op, st;
    logic [DW-1:0] key;
    logic [AW-1:0] ad;
    int            lat, est, ead, elat, r;
    bit            got, leak;
    for (int i = 0; i < 220; i++) begin
      r = int'($urandom_range(0, 99));
      op = (r < 50) ? 2'd0 : (r < 72) ? 2'd1 : (r < 98) ? 2'd2 : 2'd3;
      key = DW'(16'hA000 + $urandom_range(0, 39));
      model_apply(int'(op), key, est, ead, elat);
      send(op, key, st, ad, lat, got, leak);
      vectors++;
      if (!got || st !== 2'(est) || ad !== AW'(ead) || lat != elat || leak) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d] op=%0d key=%h: got valid=%b st=%0d addr=%0d lat=%0d leak=%b, expected st=%0d addr=%0d lat=%0d",
                 i, op, key, got, st, ad, lat, leak, est, ead, elat);
      end
      vectors++;
      if (occupancy !== (AW+1)'(m_occ) || full !== (m_occ == N)) begin
        miscompares++;
        $display("FAIL rand_occ[%0d]: got occ=%0d full=%b, expected occ=%0d full=%b",
                 i, occupancy, full, m_occ, (m_occ == N));
      end
    end
    vectors++;
    if (both_hi != 0 || unstable != 0) begin
      miscompares++;
      $display("FAIL cam_port: got overlap=%0d unstable=%0d, expected 0 0", both_hi, unstable);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_key   = '0;
    test_reset();
    test_directed();
    test_fill_full();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
